arb_requester: RTL and testbench

- Per-client front end for the N-way round-robin arbiter. Instantiate one per arbiter port.
- Buffers client words in a small FIFO and drives that client's RQT bit. Consumes the matching GNT bit.
- Issues one word onto the shared bus for each valid grant.
- Also detects spurious grants and starvation, so arbiter fairness can be checked in-system.

---
 rtl/arb_requester.sv | 77 +++++++
 tb/tb_arb_requester.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - per-client round-robin requester: FIFO, RQT/GNT handshake, spurious-grant and starvation flags
module arb_requester #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int TMO   = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          full_o,
  output logic          rqt_o,
  input  logic          gnt_i,
  output logic          bus_valid_o,
  output logic [DW-1:0] bus_data_o,
  output logic [AW:0]   level_o,
  output logic          spur_o,
  output logic          starve_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   wait_cnt;
  logic          push;
  logic          take;
  logic          wait_inc;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign level_o = count;
  assign push    = wr_en_i & ~full_o;
  assign take    = gnt_i & (count != '0);
  // Drop the request while the last word is being granted so the arbiter's
  // one-cycle latency cannot hand us a grant for an empty FIFO.
  assign rqt_o    = (count > (AW+1)'(1)) | ((count == (AW+1)'(1)) & ~gnt_i);
  assign wait_inc = rqt_o & ~gnt_i;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus_valid_o <= 1'b0;
      bus_data_o  <= '0;
      spur_o      <= 1'b0;
      starve_o    <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (take) rd_ptr <= rd_ptr + 1'b1;
      if (push && !take)      count <= count + 1'b1;
      else if (take && !push) count <= count - 1'b1;

      bus_valid_o <= take;
      if (take) bus_data_o <= mem[rd_ptr];

      if (gnt_i && (count == '0)) spur_o <= 1'b1;

      // Saturates at TMO; the flag is raised on the step that reaches it.
      if (!wait_inc) begin
        wait_cnt <= '0;
      end else if (wait_cnt == 16'(TMO - 1)) begin
        wait_cnt <= 16'(TMO);
        starve_o <= 1'b1;
      end else if (wait_cnt != 16'(TMO)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - self-checking bench for arb_requester: vector table, queue model, 4-way round-robin system
module tb_arb_requester;
  localparam int TMO = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       gnt = 1'b0;
  logic       full, rqt, bus_valid, spur, starve;
  logic [7:0] bus_data;
  logic [2:0] level;

  always #5 clk = ~clk;

  arb_requester #(.DW(8), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full), .rqt_o(rqt), .gnt_i(gnt), .bus_valid_o(bus_valid),
    .bus_data_o(bus_data), .level_o(level), .spur_o(spur), .starve_o(starve)
  );

  // Four-client system behind a registered round-robin arbiter.
  logic       rst_a = 1'b0;
  logic       arb_en = 1'b0;
  logic [3:0] a_wr = '0;
  logic [7:0] a_wdata = '0;
  logic [3:0] a_gnt, a_rqt, a_full, a_valid, a_spur, a_starve;
  logic [7:0] a_data [4];
  logic [2:0] a_level [4];
  int         arb_last, arb_pick;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cli
    arb_requester #(.DW(8), .DEPTH(DEPTH), .TMO(TMO)) u_cli (
      .clk_i(clk), .rst_ni(rst_a), .wr_en_i(a_wr[gi]), .wr_data_i(a_wdata),
      .full_o(a_full[gi]), .rqt_o(a_rqt[gi]), .gnt_i(a_gnt[gi]),
      .bus_valid_o(a_valid[gi]), .bus_data_o(a_data[gi]), .level_o(a_level[gi]),
      .spur_o(a_spur[gi]), .starve_o(a_starve[gi])
    );
  end

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  always_comb arb_pick = rr_pick(a_rqt, arb_last);

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      a_gnt    <= '0;
      arb_last <= 3;
    end else if (arb_en && arb_pick >= 0) begin
      a_gnt    <= 4'(1 << arb_pick);
      arb_last <= arb_pick;
    end else begin
      a_gnt <= '0;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word queue plus registered-output shadows.
  logic [7:0] mq [$];
  bit         m_valid, m_spur, m_starve, m_last_rqt;
  logic [7:0] m_data;
  int         m_wait;

  function automatic bit model_rqt(input bit g);
    return (mq.size() > 1) || (mq.size() == 1 && !g);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_spur = 0; m_starve = 0; m_data = '0; m_wait = 0; m_last_rqt = 0;
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit g);
    bit is_full, tk, rq;
    logic [7:0] popped;
    @(negedge clk);
    wr_en = w; wr_data = d; gnt = g;
    #1;
    check("full", full, (mq.size() == DEPTH));
    check("rqt", rqt, model_rqt(g));
    check("level", level, mq.size());
    check("bus_valid", bus_valid, m_valid);
    check("bus_data", bus_data, m_data);
    check("spur", spur, m_spur);
    check("starve", starve, m_starve);
    @(posedge clk);
    is_full = (mq.size() == DEPTH);
    tk = g && (mq.size() > 0);
    rq = model_rqt(g);
    popped = '0;
    if (tk) popped = mq.pop_front();
    if (w && !is_full) mq.push_back(d);
    m_valid = tk;
    if (tk) m_data = popped;
    if (g && !tk) m_spur = 1;
    if (rq && !g) begin
      if (m_wait + 1 >= TMO) begin m_wait = TMO; m_starve = 1; end
      else m_wait++;
    end else begin
      m_wait = 0;
    end
    m_last_rqt = rq;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; wr_en = 0; gnt = 0;
    model_reset();
    #1;
    check("rst_rqt", rqt, 0);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_valid", bus_valid, 0);
    check("rst_data", bus_data, 0);
    check("rst_spur", spur, 0);
    check("rst_starve", starve, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    bit w; logic [7:0] d; bit g;
    bit e_full; bit e_rqt; logic [2:0] e_level; bit e_valid; logic [7:0] e_data;
  } vec_t;

  vec_t vt [22];
  int   pulses [4];
  int   glog [$];

  initial begin
    vt = '{
      '{1,8'hA1,0, 0,0,3'd0,0,8'h00}, '{1,8'hA2,0, 0,1,3'd1,0,8'h00},
      '{1,8'hA3,0, 0,1,3'd2,0,8'h00}, '{1,8'hA4,0, 0,1,3'd3,0,8'h00},
      '{1,8'hA5,0, 1,1,3'd4,0,8'h00}, '{0,8'h00,1, 1,1,3'd4,0,8'h00},
      '{0,8'h00,1, 0,1,3'd3,1,8'hA1}, '{0,8'h00,1, 0,1,3'd2,1,8'hA2},
      '{0,8'h00,1, 0,0,3'd1,1,8'hA3}, '{0,8'h00,0, 0,0,3'd0,1,8'hA4},
      '{0,8'h00,0, 0,0,3'd0,0,8'hA4}, '{1,8'hB1,0, 0,0,3'd0,0,8'hA4},
      '{1,8'hB2,0, 0,1,3'd1,0,8'hA4}, '{1,8'hB3,0, 0,1,3'd2,0,8'hA4},
      '{1,8'hB4,0, 0,1,3'd3,0,8'hA4}, '{1,8'hB5,1, 1,1,3'd4,0,8'hA4},
      '{1,8'hB6,1, 0,1,3'd3,1,8'hB1}, '{0,8'h00,1, 0,1,3'd3,1,8'hB2},
      '{0,8'h00,1, 0,1,3'd2,1,8'hB3}, '{0,8'h00,1, 0,0,3'd1,1,8'hB4},
      '{0,8'h00,0, 0,0,3'd0,1,8'hB6}, '{0,8'h00,0, 0,0,3'd0,0,8'hB6}
    };

    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    rst_a = 1;

    // Three pushes with the grant looped back from last cycle's request.
    step(1, 8'h11, m_last_rqt);
    step(1, 8'h22, m_last_rqt);
    step(1, 8'h33, m_last_rqt);
    for (int i = 0; i < 5; i++) step(0, 8'h00, m_last_rqt);
    check("t1_level_end", level, 0);
    check("t1_spur_end", spur, 0);

    // Fill/drop/wrap and full push+grant vectors.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      wr_en = vt[i].w; wr_data = vt[i].d; gnt = vt[i].g;
      #1;
      check($sformatf("vec%0d_full", i), full, vt[i].e_full);
      check($sformatf("vec%0d_rqt", i), rqt, vt[i].e_rqt);
      check($sformatf("vec%0d_level", i), level, vt[i].e_level);
      check($sformatf("vec%0d_valid", i), bus_valid, vt[i].e_valid);
      check($sformatf("vec%0d_data", i), bus_data, vt[i].e_data);
    end

    // Spurious grant on an empty FIFO.
    do_reset();
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    check("spur_sticky", spur, 1);

    // Starvation: 16 requesting cycles with no grant.
    do_reset();
    step(1, 8'hC1, 0);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 0);
    #1 check("starve_after15", starve, 0);
    step(0, 8'h00, 0);
    #1 check("starve_after16", starve, 1);

    // Grant at requesting cycle 10 prevents starvation.
    do_reset();
    step(1, 8'hC2, 0);
    for (int i = 0; i < 9; i++) step(0, 8'h00, 0);
    step(0, 8'h00, 1);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 0);
    #1 check("no_starve_granted", starve, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom),
           (m_last_rqt && $urandom_range(0, 3) != 0) || ($urandom_range(0, 31) == 0));

    // Four clients on the round-robin arbiter.
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    @(negedge clk); a_wr = 4'hF; a_wdata = 8'h5A;
    @(negedge clk); a_wdata = 8'hA5;
    @(negedge clk); a_wr = 4'h0; arb_en = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (a_gnt[i]) glog.push_back(i);
        if (a_valid[i]) pulses[i]++;
      end
    end
    check("rr_grant_count", glog.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("rr_order%0d", i), (i < glog.size()) ? glog[i] : -1, i % 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_pulses%0d", i), pulses[i], 2);
    check("rr_spur", a_spur, 0);
    check("rr_starve", a_starve, 0);

    // Mid-sequence asynchronous reset.
    @(negedge clk); arb_en = 0; a_wr = 4'hF; a_wdata = 8'h77;
    @(negedge clk); a_wr = 4'h0; arb_en = 1;
    repeat (3) @(posedge clk);
    #2 rst_a = 0; arb_en = 0;
    #1;
    check("arst_rqt", a_rqt, 0);
    check("arst_full", a_full, 0);
    check("arst_valid", a_valid, 0);
    check("arst_spur", a_spur, 0);
    check("arst_starve", a_starve, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("arst_data%0d", i), a_data[i], 0);
      check($sformatf("arst_level%0d", i), a_level[i], 0);
    end
    @(negedge clk); rst_a = 1;
    repeat (2) @(negedge clk);
    check("arst_post_valid", a_valid, 0);
    check("arst_post_rqt", a_rqt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
